// File: rtl/addr_bus_arbiter_if.sv
// Request/RAM bundle for addr_bus_arbiter: per-port valid/addr/we/ready plus the single RAM address port.
// The master side drives requests and mem_ready; the slave side is the arbiter.
interface addr_bus_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int GID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS-1:0]        req_ready;
    logic                        mem_valid;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_we;
    logic                        mem_ready;
    logic [GID_W-1:0]            grant_id;

    modport master (
        output req_valid, req_addr, req_we, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_we, grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_we, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_we, grant_id
    );
endinterface

// File: rtl/addr_bus_arbiter.sv
// Arbitrates NUM_PORTS address requesters onto one registered RAM bus; request-to-mem_valid is 1 cycle.
// Holds the granted access frozen until mem_ready, then pulses req_ready[grant_id]; one access per 2 cycles max.
module addr_bus_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int MODE      = 0,
    parameter int MAX_WAIT  = 0,
    parameter int GID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    addr_bus_arbiter_if.slave bus
);
    localparam int               CNT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_nxt;
    logic                 mem_valid_q, mem_valid_nxt;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_nxt;
    logic                 mem_we_q, mem_we_nxt;
    logic [GID_W-1:0]     grant_id_q, grant_id_nxt;
    logic [NUM_PORTS-1:0] req_ready_q, req_ready_nxt;
    logic [GID_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]     wait_cnt [NUM_PORTS];
    logic [CNT_W-1:0]     wait_cnt_nxt [NUM_PORTS];

    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] starved;
    logic                 win_vld;
    logic [GID_W-1:0]     win_id;
    logic                 grant;
    int                   idx;

    // A port completing this cycle is masked so a lingering req_valid is not granted twice.
    always_comb begin
        elig    = bus.req_valid & ~req_ready_q;
        win_vld = |elig;
        win_id  = '0;
        starved = '0;
        idx     = 0;
        if (MODE == 1) begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr) + k) % NUM_PORTS;
                if (elig[idx]) win_id = GID_W'(idx);
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++)
                starved[i] = elig[i] && (MAX_WAIT > 0) && (wait_cnt[i] >= CNT_MAX);
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (starved != '0) begin
                    if (starved[i]) win_id = GID_W'(i);
                end else if (elig[i]) begin
                    win_id = GID_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        mem_valid_nxt = 1'b0;
        mem_addr_nxt  = mem_addr_q;
        mem_we_nxt    = mem_we_q;
        grant_id_nxt  = grant_id_q;
        req_ready_nxt = '0;
        rr_ptr_nxt    = rr_ptr;
        grant         = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    grant         = 1'b1;
                    state_nxt     = BUSY;
                    mem_valid_nxt = 1'b1;
                    mem_addr_nxt  = bus.req_addr[int'(win_id)*ADDR_W +: ADDR_W];
                    mem_we_nxt    = bus.req_we[win_id];
                    grant_id_nxt  = win_id;
                    rr_ptr_nxt    = (int'(win_id) == NUM_PORTS - 1) ? '0 : win_id + 1'b1;
                end
            end
            BUSY: begin
                mem_valid_nxt = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt                 = IDLE;
                    mem_valid_nxt             = 1'b0;
                    req_ready_nxt[grant_id_q] = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Starvation counters only advance on a grant; a port not requesting at that grant starts over.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            wait_cnt_nxt[i] = wait_cnt[i];
            if (grant && (MODE == 0) && (MAX_WAIT > 0)) begin
                if ((i == int'(win_id)) || !bus.req_valid[i])
                    wait_cnt_nxt[i] = '0;
                else if (wait_cnt[i] != CNT_MAX)
                    wait_cnt_nxt[i] = wait_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            grant_id_q  <= '0;
            req_ready_q <= '0;
            rr_ptr      <= '0;
            for (int i = 0; i < NUM_PORTS; i++) wait_cnt[i] <= '0;
        end else begin
            state       <= state_nxt;
            mem_valid_q <= mem_valid_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_we_q    <= mem_we_nxt;
            grant_id_q  <= grant_id_nxt;
            req_ready_q <= req_ready_nxt;
            rr_ptr      <= rr_ptr_nxt;
            for (int i = 0; i < NUM_PORTS; i++) wait_cnt[i] <= wait_cnt_nxt[i];
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.req_ready = req_ready_q;
endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Directed bench for addr_bus_arbiter: three instances (2-port fixed, 2-port fixed with MAX_WAIT=2, 4-port round-robin).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_addr_bus_arbiter;
    logic clk;
    logic rst_n;

    int n_vec;
    int n_miss;

    addr_bus_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32)) ifa ();
    addr_bus_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32)) ifb ();
    addr_bus_arbiter_if #(.NUM_PORTS(4), .ADDR_W(32)) ifc ();

    addr_bus_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .MODE(0), .MAX_WAIT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    addr_bus_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .MODE(0), .MAX_WAIT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));
    addr_bus_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .MODE(1), .MAX_WAIT(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int ga[$];
    int gb[$];
    int gc[$];
    logic pa, pb, pc;
    int exp_a[4]  = '{0, 0, 0, 0};
    int exp_b[6]  = '{0, 0, 1, 0, 0, 1};
    int exp_c1[4] = '{1, 3, 1, 3};
    int exp_c2[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        n_vec  = 0;
        n_miss = 0;
        ifa.req_valid = '0; ifa.req_addr = '0; ifa.req_we = '0; ifa.mem_ready = 1'b1;
        ifb.req_valid = '0; ifb.req_addr = '0; ifb.req_we = '0; ifb.mem_ready = 1'b1;
        ifc.req_valid = '0; ifc.mem_ready = 1'b1; ifc.req_we = '0;
        ifc.req_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mem_valid", {31'd0, ifa.mem_valid}, 32'd0);
        chk("rst_mem_addr", ifa.mem_addr, 32'd0);
        chk("rst_mem_we", {31'd0, ifa.mem_we}, 32'd0);
        chk("rst_req_ready", {30'd0, ifa.req_ready}, 32'd0);
        chk("rst_grant_id", {31'd0, ifa.grant_id}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("idle_mem_valid", {31'd0, ifa.mem_valid}, 32'd0);

        // Single fetch on port 1.
        ifa.req_addr  = {32'h0000_0040, 32'h0000_1000};
        ifa.req_we    = 2'b01;
        ifa.req_valid = 2'b10;
        tick();
        chk("fetch_mem_valid", {31'd0, ifa.mem_valid}, 32'd1);
        chk("fetch_mem_addr", ifa.mem_addr, 32'h0000_0040);
        chk("fetch_grant_id", {31'd0, ifa.grant_id}, 32'd1);
        chk("fetch_mem_we", {31'd0, ifa.mem_we}, 32'd0);
        ifa.req_valid = 2'b00;
        tick();
        chk("fetch_req_ready", {30'd0, ifa.req_ready}, 32'b10);
        chk("fetch_done_valid", {31'd0, ifa.mem_valid}, 32'd0);
        tick();
        chk("fetch_ready_pulse", {30'd0, ifa.req_ready}, 32'b00);

        // Stall: port 0 at 0x2000 held for 5 cycles while port 1 address toggles.
        ifa.req_addr  = {32'h0000_0040, 32'h0000_2000};
        ifa.req_we    = 2'b00;
        ifa.mem_ready = 1'b0;
        ifa.req_valid = 2'b01;
        tick();
        chk("stall_grant", {31'd0, ifa.mem_valid}, 32'd1);
        chk("stall_gid", {31'd0, ifa.grant_id}, 32'd0);
        ifa.req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            ifa.req_addr[63:32] = (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h0000_0040;
            tick();
            chk("stall_addr", ifa.mem_addr, 32'h0000_2000);
            chk("stall_ready", {30'd0, ifa.req_ready}, 32'd0);
        end
        ifa.mem_ready = 1'b1;
        tick();
        chk("stall_ready_pulse", {30'd0, ifa.req_ready}, 32'b01);
        chk("stall_release", {31'd0, ifa.mem_valid}, 32'd0);
        tick();
        chk("stall_ready_once", {30'd0, ifa.req_ready}, 32'b00);

        // Double-grant guard: port 0 keeps req_valid through its req_ready cycle.
        ifa.req_addr  = {32'h0000_0040, 32'h0000_1000};
        ifa.req_we    = 2'b01;
        ifa.req_valid = 2'b11;
        tick();
        chk("dg_first_gid", {31'd0, ifa.grant_id}, 32'd0);
        chk("dg_first_we", {31'd0, ifa.mem_we}, 32'd1);
        tick();
        chk("dg_ready0", {30'd0, ifa.req_ready}, 32'b01);
        tick();
        ifa.req_valid = 2'b00;
        chk("dg_second_valid", {31'd0, ifa.mem_valid}, 32'd1);
        chk("dg_second_gid", {31'd0, ifa.grant_id}, 32'd1);
        repeat (3) tick();

        // Fixed priority on A (MAX_WAIT=0) and B (MAX_WAIT=2); port 1 defers in port 0's completion cycle.
        ifb.req_addr  = {32'h0000_0040, 32'h0000_1000};
        ifb.req_we    = 2'b01;
        ifa.req_valid = 2'b11;
        ifb.req_valid = 2'b11;
        pa = ifa.mem_valid;
        pb = ifb.mem_valid;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (ifa.mem_valid && !pa) begin
                ga.push_back(int'(ifa.grant_id));
                if (ifa.grant_id == 1'b0) chk("fix_a_addr", ifa.mem_addr, 32'h0000_1000);
            end
            if (ifb.mem_valid && !pb) gb.push_back(int'(ifb.grant_id));
            pa = ifa.mem_valid;
            pb = ifb.mem_valid;
            ifa.req_valid[1] = !ifa.req_ready[0];
            ifb.req_valid[1] = !ifb.req_ready[0];
        end
        ifa.req_valid = 2'b00;
        ifb.req_valid = 2'b00;
        for (int i = 0; i < 4; i++)
            chk($sformatf("fix_a_grant%0d", i), (i < ga.size()) ? ga[i] : 99, exp_a[i]);
        for (int i = 0; i < 6; i++)
            chk($sformatf("fix_b_grant%0d", i), (i < gb.size()) ? gb[i] : 99, exp_b[i]);
        repeat (3) tick();

        // Round-robin: ports 1 and 3 only, then all four.
        ifc.req_valid = 4'b1010;
        pc = ifc.mem_valid;
        for (int c = 0; c < 40 && gc.size() < 4; c++) begin
            tick();
            if (ifc.mem_valid && !pc) begin
                gc.push_back(int'(ifc.grant_id));
                if (gc.size() == 4) ifc.req_valid = 4'b0000;
            end
            pc = ifc.mem_valid;
        end
        ifc.req_valid = 4'b0000;
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr13_grant%0d", i), (i < gc.size()) ? gc[i] : 99, exp_c1[i]);
        repeat (3) tick();
        gc.delete();
        ifc.req_valid = 4'b1111;
        pc = ifc.mem_valid;
        for (int c = 0; c < 40 && gc.size() < 6; c++) begin
            tick();
            if (ifc.mem_valid && !pc) begin
                gc.push_back(int'(ifc.grant_id));
                chk("rr_addr", ifc.mem_addr, 32'h100 * exp_c2[gc.size() - 1]);
                if (gc.size() == 6) ifc.req_valid = 4'b0000;
            end
            pc = ifc.mem_valid;
        end
        ifc.req_valid = 4'b0000;
        for (int i = 0; i < 6; i++)
            chk($sformatf("rr_all_grant%0d", i), (i < gc.size()) ? gc[i] : 99, exp_c2[i]);
        repeat (3) tick();

        // Reset mid-access with mem_addr = 0x1000.
        ifa.req_addr  = {32'h0000_0040, 32'h0000_1000};
        ifa.mem_ready = 1'b0;
        ifa.req_valid = 2'b01;
        tick();
        ifa.req_valid = 2'b00;
        chk("mid_busy_addr", ifa.mem_addr, 32'h0000_1000);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, ifa.mem_valid}, 32'd0);
        chk("mid_rst_addr", ifa.mem_addr, 32'd0);
        chk("mid_rst_ready", {30'd0, ifa.req_ready}, 32'd0);
        chk("mid_rst_gid", {31'd0, ifa.grant_id}, 32'd0);
        ifa.mem_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_ready", {30'd0, ifa.req_ready}, 32'd0);
            chk("post_rst_valid", {31'd0, ifa.mem_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/addr_bus_arbiter.md
Name: addr_bus_arbiter

Overview:
- Parametrised successor to the two-input RAM address-bus select: arbitrates NUM_PORTS address requesters (data LDR/STR, PC fetch, future DMA/debug) onto one registered RAM address bus.
- Adds a valid/ready handshake with multi-cycle stall support, fixed-priority or round-robin selection, and starvation protection.
- Sits between the memory-control/PC blocks and the RAM port.

Parameters:
- NUM_PORTS, 2, number of requesters, 2..8; port 0 is the data (LDR/STR) port by convention.
- ADDR_W, 32, address width in bits.
- MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- MAX_WAIT, 0, fixed-mode starvation limit in lost grants; 0 disables. Ignored when MODE = 1.
- GID_W, max(1, clog2(NUM_PORTS)), derived width of grant_id. Not to be overridden.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, NUM_PORTS: per-port request.
- req_addr, in, NUM_PORTS*ADDR_W: packed addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- req_we, in, NUM_PORTS: per-port write flag (1 = STR).
- req_ready, out, NUM_PORTS: one-cycle completion pulse per port.
- mem_valid, out, 1: RAM access in progress.
- mem_addr, out, ADDR_W: address to RAM.
- mem_we, out, 1: write enable to RAM.
- mem_ready, in, 1: RAM accepts/completes the access.
- grant_id, out, GID_W: index of the currently or most recently granted port.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; mem_valid = 0, mem_addr = 0, mem_we = 0, req_ready = 0, grant_id = 0; RR pointer = 0; all wait counters = 0. Reset mid-access aborts the access and sends no req_ready.
- FSM has two states, IDLE and BUSY.
- IDLE, with any eligible req_valid:
  - Select a winner w.
  - On the next edge register mem_addr = req_addr[w], mem_we = req_we[w], grant_id = w, mem_valid = 1, and go to BUSY.
  - Request-to-mem_valid latency is 1 cycle.
- Eligibility: port i is masked in any cycle where req_ready[i] = 1. This prevents a double grant while the requester drops its request.
- IDLE, with no eligible request: stay in IDLE. mem_valid = 0; mem_addr, mem_we and grant_id hold their last values.
- BUSY:
  - mem_addr, mem_we and grant_id are frozen.
  - Changes on req_* have no effect, including the granted port dropping req_valid.
  - On an edge with mem_ready = 1: mem_valid goes to 0, req_ready[grant_id] goes to 1 for exactly one cycle, and state returns to IDLE.
- mem_ready is ignored whenever mem_valid = 0.
- req_ready: at most one bit is set in any cycle; it is registered and is low in every other cycle.
- Throughput: at most one access per 2 cycles (BUSY then IDLE); a zero-wait RAM gives a 2-cycle cadence.
- Fixed mode (MODE = 0):
  - The lowest valid index wins, unless any port is starved.
  - A port is starved when wait_cnt[i] >= MAX_WAIT and MAX_WAIT > 0. The lowest-index starved port wins.
  - wait_cnt[i] increments (saturating at MAX_WAIT) on each grant to another port while req_valid[i] = 1.
  - wait_cnt[i] clears when port i is granted or when req_valid[i] = 0 at a grant.
- Round-robin mode (MODE = 1):
  - Search starts at the RR pointer and wraps modulo NUM_PORTS.
  - On a grant, pointer = (w + 1) mod NUM_PORTS; wrap from NUM_PORTS-1 to 0.
  - The pointer is unchanged when no grant occurs.
- Address/width: ADDR_W passes through unmodified, with no alignment checks. Unused grant_id encodings never occur.
- Simultaneous events:
  - mem_ready and a new request in the same BUSY cycle: the new request is arbitrated in the following IDLE cycle.
  - Reset dominates all other events.

Test Plan:
- Reset mid-access: rst_n low while BUSY with mem_addr = 0x0000_1000 -> mem_valid, mem_addr, req_ready and grant_id are 0 immediately (asynchronous); after release, state is IDLE and no req_ready pulse occurs.
- Single fetch: NUM_PORTS = 2, port 1 valid with address 0x0000_0040, mem_ready tied 1 -> next cycle mem_valid = 1, mem_addr = 0x40, grant_id = 1, mem_we = 0; the following cycle req_ready = 2'b10 for 1 cycle.
- Fixed priority, both ports held valid (port 0 = 0x1000 we = 1, port 1 = 0x0040), zero-wait RAM:
  - MAX_WAIT = 0 -> grant sequence 0,0,0,0.
  - MAX_WAIT = 2 -> grant sequence 0,0,1,0,0,1.
- Round-robin: NUM_PORTS = 4, MODE = 1, all valid -> grants 0,1,2,3,0,1. With only ports 1 and 3 valid -> 1,3,1,3.
- Stall: mem_ready = 0 for 5 cycles after grant to port 0 (address 0x2000), with port 1 address toggling -> mem_addr stable at 0x2000 and req_ready = 0 throughout; a single req_ready[0] pulse follows the mem_ready edge.
- Double-grant guard: port 0 holds req_valid for one cycle after its req_ready while port 1 is valid -> next grant_id = 1, not 0.
